// File: rtl/vec_pack_pkg.sv
// vec_pack_pkg: shared read-FSM state type and byte-mask helper
// for the s8 vector pack stream buffer.
package vec_pack_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    OUTPUT
  } state_t;

  function automatic logic [7:0] lsb_mask(
    input int n,
    input int ob
  );
    logic [7:0] m;
    m = '0;
    for (int i = 0; i < 8; i++)
      m[i] = (i < n) && (i < ob);
    return m;
  endfunction

endpackage

// File: rtl/vec_bank_ring_ctrl.sv
// vec_bank_ring_ctrl: bank ring bookkeeping -- write/read pointers,
// per-bank committed flags and row counts, input backpressure.
module vec_bank_ring_ctrl
  import vec_pack_pkg::*;
#(
  parameter int NUM_BANKS = 2,
  parameter int DEPTH     = 16,
  localparam int BW = $clog2(NUM_BANKS),
  localparam int RW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          wr_acc,
  input  logic          wr_last,
  input  logic          rd_rel,
  output logic [BW-1:0] wr_bank,
  output logic [RW-1:0] wcnt,
  output logic          in_ready,
  output logic          full,
  output logic [BW-1:0] rd_bank,
  output logic          rd_committed,
  output logic [RW-1:0] rd_rows
);

  logic [NUM_BANKS-1:0] cmt_q, cmt_d;
  logic [RW-1:0]        rows_q [NUM_BANKS];
  logic [RW-1:0]        rows_d [NUM_BANKS];
  logic [BW-1:0]        wr_bank_q, wr_bank_d;
  logic [BW-1:0]        rd_bank_q, rd_bank_d;
  logic [RW-1:0]        wcnt_q, wcnt_d;
  logic                 commit;

  always_comb begin
    commit    = wr_acc &&
                (wr_last || int'(wcnt_q) == DEPTH - 1);
    cmt_d     = cmt_q;
    rows_d    = rows_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wcnt_d    = wcnt_q;
    if (wr_acc)
      wcnt_d = wcnt_q + RW'(1);
    // commit and release always target different banks
    if (commit) begin
      cmt_d[wr_bank_q]  = 1'b1;
      rows_d[wr_bank_q] = wcnt_q + RW'(1);
      wr_bank_d         = wr_bank_q + BW'(1);
      wcnt_d            = '0;
    end
    if (rd_rel) begin
      cmt_d[rd_bank_q] = 1'b0;
      rd_bank_d        = rd_bank_q + BW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cmt_q     <= '0;
      wr_bank_q <= '0;
      rd_bank_q <= '0;
      wcnt_q    <= '0;
      for (int i = 0; i < NUM_BANKS; i++)
        rows_q[i] <= '0;
    end else begin
      cmt_q     <= cmt_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wcnt_q    <= wcnt_d;
      rows_q    <= rows_d;
    end
  end

  assign wr_bank      = wr_bank_q;
  assign rd_bank      = rd_bank_q;
  assign wcnt         = wcnt_q;
  assign in_ready     = ~cmt_q[wr_bank_q];
  assign full         = cmt_q[wr_bank_q];
  assign rd_committed = cmt_q[rd_bank_q];
  assign rd_rows      = rows_q[rd_bank_q];

endmodule

// File: rtl/vec_s8_pack_stream.sv
// vec_s8_pack_stream: banked s8 vector buffer drained as masked
// OUT_BYTES-wide words with row/bank end markers.
module vec_s8_pack_stream
  import vec_pack_pkg::*;
#(
  parameter int VLEN      = 16,
  parameter int OUT_BYTES = 4,
  parameter int NUM_BANKS = 2,
  parameter int DEPTH     = 16,
  localparam int NCW = $clog2(VLEN) + 1,
  localparam int OW  = 8 * OUT_BYTES
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_last,
  input  logic signed [8*VLEN-1:0] in_vec_s8,
  output logic                   output_req,
  input  logic                   req_ack,
  input  logic [NCW-1:0]         vec_valid_num_col,
  output logic                   output_valid,
  input  logic                   output_ready,
  output logic [OUT_BYTES-1:0]   output_mask,
  output logic [OW-1:0]          output_data,
  output logic                   output_switch_row,
  output logic                   output_last,
  output logic                   fifo_full_flag
);

  localparam int BW = $clog2(NUM_BANKS);
  localparam int RW = $clog2(DEPTH) + 1;
  localparam int WW = $clog2(VLEN / OUT_BYTES) + 1;
  localparam int AW = $clog2(NUM_BANKS * DEPTH);

  logic [BW-1:0] wr_bank, rd_bank;
  logic [RW-1:0] wcnt, rd_rows;
  logic          rd_committed, acc, rel, load;

  assign acc = in_valid & in_ready;

  vec_bank_ring_ctrl #(
    .NUM_BANKS (NUM_BANKS),
    .DEPTH     (DEPTH)
  ) u_ring (
    .clk          (clk),
    .rstn         (rstn),
    .wr_acc       (acc),
    .wr_last      (in_last),
    .rd_rel       (rel),
    .wr_bank      (wr_bank),
    .wcnt         (wcnt),
    .in_ready     (in_ready),
    .full         (fifo_full_flag),
    .rd_bank      (rd_bank),
    .rd_committed (rd_committed),
    .rd_rows      (rd_rows)
  );

  logic [8*VLEN-1:0] mem_q [NUM_BANKS*DEPTH];
  logic [AW-1:0]     wr_addr, rd_addr;

  assign wr_addr = AW'(int'(wr_bank) * DEPTH + int'(wcnt));

  always_ff @(posedge clk) begin
    if (acc)
      mem_q[wr_addr] <= in_vec_s8;
  end

  state_t               state_q, state_d;
  logic [NCW-1:0]       ncol_q, ncol_d;
  logic [RW-1:0]        row_q, row_d;
  logic [WW-1:0]        word_q, word_d;
  logic                 ov_q, ov_d;
  logic [OW-1:0]        data_q, data_d;
  logic [OUT_BYTES-1:0] mask_q, mask_d;
  logic                 sr_q, sr_d;
  logic                 last_q, last_d;

  logic [NCW-1:0]       sel_ncol;
  logic [RW-1:0]        sel_row, nxt_row;
  logic [WW-1:0]        sel_word, nxt_word;
  logic [8*VLEN-1:0]    g_vec;
  logic [OW-1:0]        g_data;
  logic [OUT_BYTES-1:0] g_mask;
  logic                 g_sr, g_last;
  int                   nw, rem;

  // word generator: in REQ it prepares word 0 from the ack'd ncol
  always_comb begin
    if (state_q == REQ) begin
      sel_ncol = vec_valid_num_col;
      sel_row  = '0;
      sel_word = '0;
    end else begin
      sel_ncol = ncol_q;
      sel_row  = row_q;
      sel_word = word_q;
    end
    nw       = (int'(sel_ncol) + OUT_BYTES - 1) / OUT_BYTES;
    rem      = int'(sel_ncol) - int'(sel_word) * OUT_BYTES;
    rd_addr  = AW'(int'(rd_bank) * DEPTH + int'(sel_row));
    g_vec    = mem_q[rd_addr];
    g_data   = OW'(g_vec >> (int'(sel_word) * OW));
    g_mask   = OUT_BYTES'(lsb_mask(rem, OUT_BYTES));
    g_sr     = int'(sel_word) == nw - 1;
    g_last   = g_sr && int'(sel_row) == int'(rd_rows) - 1;
    nxt_word = g_sr ? '0 : sel_word + WW'(1);
    nxt_row  = g_sr ? sel_row + RW'(1) : sel_row;
  end

  always_comb begin
    state_d = state_q;
    ncol_d  = ncol_q;
    row_d   = row_q;
    word_d  = word_q;
    ov_d    = ov_q;
    data_d  = data_q;
    mask_d  = mask_q;
    sr_d    = sr_q;
    last_d  = last_q;
    rel     = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rd_committed)
          state_d = REQ;
      end
      REQ: begin
        if (req_ack) begin
          ncol_d = vec_valid_num_col;
          if (vec_valid_num_col == '0) begin
            rel     = 1'b1;
            state_d = IDLE;
          end else begin
            load    = 1'b1;
            state_d = OUTPUT;
          end
        end
      end
      OUTPUT: begin
        if (ov_q && output_ready) begin
          if (last_q) begin
            rel     = 1'b1;
            state_d = IDLE;
            ov_d    = 1'b0;
            data_d  = '0;
            mask_d  = '0;
            sr_d    = 1'b0;
            last_d  = 1'b0;
          end else begin
            load = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      ov_d   = 1'b1;
      data_d = g_data;
      mask_d = g_mask;
      sr_d   = g_sr;
      last_d = g_last;
      row_d  = nxt_row;
      word_d = nxt_word;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      ncol_q  <= '0;
      row_q   <= '0;
      word_q  <= '0;
      ov_q    <= 1'b0;
      data_q  <= '0;
      mask_q  <= '0;
      sr_q    <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ncol_q  <= ncol_d;
      row_q   <= row_d;
      word_q  <= word_d;
      ov_q    <= ov_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      sr_q    <= sr_d;
      last_q  <= last_d;
    end
  end

  assign output_req        = (state_q == REQ);
  assign output_valid      = ov_q;
  assign output_data       = data_q;
  assign output_mask       = mask_q;
  assign output_switch_row = sr_q;
  assign output_last       = last_q;

endmodule

// File: tb/tb_vec_s8_pack_stream.sv
// tb_vec_s8_pack_stream: directed scenario bench for the s8 vector
// pack stream buffer (VLEN=16, OUT_BYTES=4, NUM_BANKS=2, DEPTH=16).
module tb_vec_s8_pack_stream;

  localparam int VLEN  = 16;
  localparam int OB    = 4;
  localparam int NB    = 2;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic req_ack = 1'b0;
  logic output_ready = 1'b0;
  logic signed [8*VLEN-1:0] in_vec_s8 = '0;
  logic [4:0] vec_valid_num_col = '0;
  logic in_ready, output_req, output_valid;
  logic output_switch_row, output_last, fifo_full_flag;
  logic [OB-1:0] output_mask;
  logic [8*OB-1:0] output_data;

  int checks = 0;
  int errors = 0;
  int stall_bad = 0;
  logic [37:0] q_word[$];

  always #5 clk = ~clk;

  vec_s8_pack_stream #(
    .VLEN (VLEN), .OUT_BYTES (OB),
    .NUM_BANKS (NB), .DEPTH (DEPTH)
  ) dut (
    .clk (clk), .rstn (rstn),
    .in_valid (in_valid), .in_ready (in_ready),
    .in_last (in_last), .in_vec_s8 (in_vec_s8),
    .output_req (output_req), .req_ack (req_ack),
    .vec_valid_num_col (vec_valid_num_col),
    .output_valid (output_valid),
    .output_ready (output_ready),
    .output_mask (output_mask),
    .output_data (output_data),
    .output_switch_row (output_switch_row),
    .output_last (output_last),
    .fifo_full_flag (fifo_full_flag)
  );

  function automatic logic [7:0] vbyte(int tag, int k, int j);
    return 8'(tag * 40 + k * 7 + j * 3 + 1);
  endfunction

  function automatic logic [8*VLEN-1:0] vvec(int tag, int k);
    logic [8*VLEN-1:0] v;
    for (int j = 0; j < VLEN; j++)
      v[j*8 +: 8] = vbyte(tag, k, j);
    return v;
  endfunction

  // expected {last, switch_row, mask, valid bytes} of word idx
  function automatic logic [37:0] exp_word(
    int tag, int kbase, int rows, int ncol, int idx);
    int nw, r, w, e;
    logic [3:0] m;
    logic [31:0] d;
    nw = (ncol + OB - 1) / OB;
    r = idx / nw;
    w = idx % nw;
    m = '0;
    d = '0;
    for (int i = 0; i < OB; i++) begin
      e = w * OB + i;
      if (e < ncol) begin
        m[i] = 1'b1;
        d[i*8 +: 8] = vbyte(tag, kbase + r, e);
      end
    end
    return {(w == nw - 1) && (r == rows - 1), w == nw - 1, m, d};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 0; in_last = 0; req_ack = 0;
    output_ready = 0; rstn = 0;
    step(); step();
    rstn = 1;
    step();
  endtask

  task automatic send_vec(int tag, int k, bit last);
    int t;
    t = 0;
    in_valid = 1;
    in_last = last;
    in_vec_s8 = vvec(tag, k);
    while (!in_ready && t < 50) begin
      step();
      t++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready %0b want 1", in_ready);
    end
    step();
    in_valid = 0;
    in_last = 0;
  endtask

  task automatic do_ack(int ncol);
    int t;
    t = 0;
    while (!output_req && t < 50) begin
      step();
      t++;
    end
    if (!output_req) begin
      checks++; errors++;
      $display("FAIL req_timeout: output_req %0b want 1", output_req);
    end
    vec_valid_num_col = 5'(ncol);
    req_ack = 1;
    step();
    req_ack = 0;
  endtask

  task automatic collect(int mode, int budget,
                         output int got, output int cyc);
    logic [31:0] bm;
    logic [37:0] held;
    bit stalled, done;
    got = 0; cyc = 0; stalled = 0; done = 0;
    held = '0;
    q_word.delete();
    for (int c = 0; c < budget && !done; c++) begin
      output_ready = mode ? 1'($urandom_range(0, 1)) : 1'b1;
      for (int i = 0; i < OB; i++)
        bm[i*8 +: 8] = {8{output_mask[i]}};
      if (stalled && held !== {output_last, output_switch_row,
                               output_mask, output_data})
        stall_bad++;
      if (output_valid && output_ready) begin
        q_word.push_back({output_last, output_switch_row,
                          output_mask, output_data & bm});
        got++;
        done = output_last;
      end
      stalled = output_valid && !output_ready;
      held = {output_last, output_switch_row,
              output_mask, output_data};
      step();
      cyc++;
    end
    output_ready = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (output_valid !== 1'b0) begin errors++;
      $display("FAIL rst_valid: got %0b want 0", output_valid); end
    checks++;
    if (output_req !== 1'b0) begin errors++;
      $display("FAIL rst_req: got %0b want 0", output_req); end
    checks++;
    if ({in_ready, fifo_full_flag} !== 2'b10) begin errors++;
      $display("FAIL rst_ready_full: got %b want 10",
               {in_ready, fifo_full_flag}); end
    checks++;
    if ({output_last, output_switch_row, output_mask,
         output_data} !== 38'h0) begin errors++;
      $display("FAIL rst_word: got %h want 0",
               {output_last, output_switch_row,
                output_mask, output_data}); end
  endtask

  task automatic test_full_rows();
    int got, cyc;
    for (int k = 0; k < 3; k++) send_vec(1, k, k == 2);
    do_ack(16);
    checks++;
    if (output_valid !== 1'b1) begin errors++;
      $display("FAIL full_latency: valid %0b want 1", output_valid); end
    collect(0, 40, got, cyc);
    checks++;
    if (got !== 12) begin errors++;
      $display("FAIL full_count: got %0d want 12", got); end
    checks++;
    if (cyc !== 12) begin errors++;
      $display("FAIL full_cycles: got %0d want 12", cyc); end
    for (int i = 0; i < got && i < 12; i++) begin
      checks++;
      if (q_word[i] !== exp_word(1, 0, 3, 16, i)) begin errors++;
        $display("FAIL full_word%0d: got %h want %h", i,
                 q_word[i], exp_word(1, 0, 3, 16, i)); end
    end
  endtask

  task automatic test_partial();
    int got, cyc;
    for (int k = 0; k < 2; k++) send_vec(2, k, k == 1);
    do_ack(10);
    collect(0, 40, got, cyc);
    checks++;
    if (got !== 6) begin errors++;
      $display("FAIL part_count: got %0d want 6", got); end
    for (int i = 0; i < got && i < 6; i++) begin
      checks++;
      if (q_word[i] !== exp_word(2, 0, 2, 10, i)) begin errors++;
        $display("FAIL part_word%0d: got %h want %h", i,
                 q_word[i], exp_word(2, 0, 2, 10, i)); end
    end
  endtask

  task automatic test_full_flag();
    int got, cyc;
    send_vec(3, 0, 1);
    send_vec(3, 1, 1);
    checks++;
    if ({in_ready, fifo_full_flag} !== 2'b01) begin errors++;
      $display("FAIL ff_full: got %b want 01",
               {in_ready, fifo_full_flag}); end
    do_ack(16);
    collect(0, 40, got, cyc);
    checks++;
    if (got !== 4) begin errors++;
      $display("FAIL ff_count0: got %0d want 4", got); end
    checks++;
    if ({in_ready, fifo_full_flag} !== 2'b10) begin errors++;
      $display("FAIL ff_freed: got %b want 10",
               {in_ready, fifo_full_flag}); end
    do_ack(16);
    collect(0, 40, got, cyc);
    checks++;
    if (got !== 4) begin errors++;
      $display("FAIL ff_count1: got %0d want 4", got); end
    checks++;
    if (q_word.size() == 0 || q_word[0] !== exp_word(3, 1, 1, 16, 0))
    begin errors++;
      $display("FAIL ff_bank1_word0: got %h want %h",
               q_word.size() ? q_word[0] : 38'h0,
               exp_word(3, 1, 1, 16, 0)); end
  endtask

  task automatic test_overflow();
    int got, cyc;
    for (int k = 0; k < 17; k++) send_vec(4, k, k == 16);
    do_ack(4);
    collect(0, 40, got, cyc);
    checks++;
    if (got !== 16) begin errors++;
      $display("FAIL ovf_count0: got %0d want 16", got); end
    for (int i = 0; i < got && i < 16; i++) begin
      checks++;
      if (q_word[i] !== exp_word(4, 0, 16, 4, i)) begin errors++;
        $display("FAIL ovf_word%0d: got %h want %h", i,
                 q_word[i], exp_word(4, 0, 16, 4, i)); end
    end
    do_ack(4);
    collect(0, 40, got, cyc);
    checks++;
    if (got !== 1) begin errors++;
      $display("FAIL ovf_count1: got %0d want 1", got); end
    checks++;
    if (q_word.size() == 0 || q_word[0] !== exp_word(4, 16, 1, 4, 0))
    begin errors++;
      $display("FAIL ovf_bank1: got %h want %h",
               q_word.size() ? q_word[0] : 38'h0,
               exp_word(4, 16, 1, 4, 0)); end
  endtask

  task automatic test_back_to_back_stall();
    int got, cyc;
    stall_bad = 0;
    for (int k = 0; k < 4; k++) send_vec(5, k, k == 3);
    do_ack(13);
    collect(1, 300, got, cyc);
    checks++;
    if (got !== 16) begin errors++;
      $display("FAIL rnd_count: got %0d want 16", got); end
    checks++;
    if (stall_bad !== 0) begin errors++;
      $display("FAIL rnd_stable: got %0d changes want 0", stall_bad); end
    for (int i = 0; i < got && i < 16; i++) begin
      checks++;
      if (q_word[i] !== exp_word(5, 0, 4, 13, i)) begin errors++;
        $display("FAIL rnd_word%0d: got %h want %h", i,
                 q_word[i], exp_word(5, 0, 4, 13, i)); end
    end
  endtask

  task automatic test_zero_ncol();
    int seen;
    seen = 0;
    send_vec(6, 0, 1);
    do_ack(0);
    output_ready = 1;
    for (int c = 0; c < 6; c++) begin
      if (output_valid || output_req) seen++;
      step();
    end
    output_ready = 0;
    checks++;
    if (seen !== 0) begin errors++;
      $display("FAIL zero_words: got %0d active cycles want 0", seen); end
    checks++;
    if (in_ready !== 1'b1) begin errors++;
      $display("FAIL zero_freed: in_ready %0b want 1", in_ready); end
  endtask

  task automatic test_reset_mid();
    int seen;
    seen = 0;
    for (int k = 0; k < 2; k++) send_vec(7, k, k == 1);
    do_ack(16);
    output_ready = 1;
    step(); step(); step();
    rstn = 0;
    #1;
    checks++;
    if ({output_valid, output_req, output_last,
         output_switch_row, output_mask, output_data} !== 40'h0)
    begin errors++;
      $display("FAIL rmid_outs: valid %0b req %0b data %h want 0",
               output_valid, output_req, output_data); end
    checks++;
    if ({in_ready, fifo_full_flag} !== 2'b10) begin errors++;
      $display("FAIL rmid_ready: got %b want 10",
               {in_ready, fifo_full_flag}); end
    step();
    rstn = 1;
    for (int c = 0; c < 6; c++) begin
      if (output_valid || output_req) seen++;
      step();
    end
    output_ready = 0;
    checks++;
    if (seen !== 0) begin errors++;
      $display("FAIL rmid_after: got %0d active cycles want 0", seen); end
  endtask

  initial begin
    test_reset();
    test_full_rows();
    test_partial();
    test_full_flag();
    test_overflow();
    test_back_to_back_stall();
    test_zero_ncol();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
